// File: rtl/scan_decoder.sv
// Registered one-hot decoder with prescaled up/down scanning,
// mid-scan load and blanking; all outputs come straight from flops.
module scan_decoder #(
    parameter int IN_W     = 5,
    parameter int PRESCALE = 4,
    localparam int OUT_W   = 2 ** IN_W
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic [1:0]       MODE,
    input  logic             LOAD,
    input  logic [IN_W-1:0]  INPUT,
    output logic [OUT_W-1:0] OUTPUT,
    output logic [IN_W-1:0]  INDEX,
    output logic             WRAP
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] TC = PW'(PRESCALE - 1);
    localparam logic [OUT_W-1:0] ONE = {{(OUT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        M_DIRECT = 2'b00,
        M_UP     = 2'b01,
        M_DOWN   = 2'b10,
        M_BLANK  = 2'b11
    } mode_e;

    mode_e mode;
    assign mode = mode_e'(MODE);

    logic [IN_W-1:0]  idx_q, idx_d;
    logic [OUT_W-1:0] out_q, out_d;
    logic [PW-1:0]    pre_q, pre_d;
    logic             wrap_q, wrap_d;

    always_comb begin
        idx_d  = idx_q;
        out_d  = out_q;
        pre_d  = pre_q;
        wrap_d = 1'b0;
        if (EN) begin
            unique case (mode)
                M_DIRECT: begin
                    idx_d = INPUT;
                    pre_d = '0;
                end
                M_UP, M_DOWN: begin
                    // A load discards any step due on the same edge
                    if (LOAD) begin
                        idx_d = INPUT;
                        pre_d = '0;
                    end else if (pre_q == TC) begin
                        pre_d = '0;
                        if (mode == M_UP) begin
                            idx_d  = idx_q + IN_W'(1);
                            wrap_d = &idx_q;
                        end else begin
                            idx_d  = idx_q - IN_W'(1);
                            wrap_d = ~|idx_q;
                        end
                    end else begin
                        pre_d = pre_q + PW'(1);
                    end
                end
                M_BLANK: begin
                    pre_d = '0;
                end
            endcase
            out_d = (mode == M_BLANK) ? '0 : (ONE << idx_d);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            idx_q  <= '0;
            out_q  <= ONE;
            pre_q  <= '0;
            wrap_q <= 1'b0;
        end else begin
            idx_q  <= idx_d;
            out_q  <= out_d;
            pre_q  <= pre_d;
            wrap_q <= wrap_d;
        end
    end

    assign INDEX  = idx_q;
    assign OUTPUT = out_q;
    assign WRAP   = wrap_q;

endmodule

// File: doc/scan_decoder.md
# scan_decoder

Parametrised registered one-hot decoder, successor to the combinational 5-to-32 decoder. Besides direct decoding of INPUT, it can autonomously scan its one-hot output up or down at a prescaled rate, which drives digit/LED select lines and row strobes. It can also be loaded mid-scan or blanked. It sits between control logic and display or select fabric, and all outputs are registered.

## Interface
- IN_W, default 5: index width; output width OUT_W = 2**IN_W (derived, not overridable).
- PRESCALE, default 4: enabled cycles per scan step, ≥1.
- CLK  in  1: rising-edge clock.
- RST  in  1: synchronous, active-high reset.
- EN  in  1: clock enable; when low all state holds.
- MODE  in  2: 00 direct, 01 scan up, 10 scan down, 11 blank.
- LOAD  in  1: in scan modes, load INPUT as the current index.
- INPUT  in  IN_W: index to decode or load.
- OUTPUT  out  OUT_W: registered one-hot of INDEX, or all-zero in blank mode.
- INDEX  out  IN_W: registered current index.
- WRAP  out  1: one-cycle pulse after a scan wrap-around.

## Operation
- Reset, when RST is high at an edge:
  - INDEX=0, OUTPUT=1 (bit 0 only), WRAP=0, prescaler=0.
  - Reset has priority over EN and all other inputs.
- EN=0: INDEX, OUTPUT and prescaler hold. WRAP goes to 0 at the next edge.
- MODE 00, direct:
  - INDEX<=INPUT and OUTPUT<=1<<INPUT.
  - Prescaler cleared. LOAD ignored. WRAP=0.
- MODE 01/10, scan:
  - If LOAD=1: INDEX<=INPUT, prescaler<=0, no step, WRAP=0.
  - Otherwise the prescaler increments each enabled cycle.
  - When prescaler==PRESCALE-1: prescaler<=0 and INDEX steps ±1, modulo OUT_W.
  - WRAP<=1 on the step OUT_W-1→0 (up) or 0→OUT_W-1 (down). Otherwise WRAP<=0.
- MODE 11, blank:
  - OUTPUT<=0. INDEX holds. Prescaler cleared. LOAD ignored. WRAP=0.
- Switching between 01 and 10 keeps both the prescaler and INDEX.
- Leaving 11 for a scan mode restores OUTPUT=1<<INDEX at the next enabled edge.
- Invariant: outside blank mode, OUTPUT is exactly one-hot and equals 1<<INDEX.

## Timing
- All outputs change only on the rising edge of CLK.
- Direct mode: latency 1 cycle from INPUT to OUTPUT/INDEX.
- Scan mode, LOAD=0, EN held high: INDEX changes every PRESCALE cycles.
  - First step occurs PRESCALE edges after entering scan mode or after a LOAD.
  - PRESCALE=1 steps on every enabled edge.
- LOAD takes effect at the edge where it is sampled, with latency 1. LOAD beats a coincident prescaler terminal count: the step is discarded.
- WRAP is high for exactly one cycle, in the cycle after the wrapping edge, coincident with INDEX=0 (up) or INDEX=OUT_W-1 (down).
- MODE change takes effect at the same edge it is sampled.
- Mid-scan reset gives the reset values at the next edge. Scanning resumes from index 0 with a full PRESCALE delay.

## Test plan
- Default parameters, EN=1, MODE=00, INPUT swept 0..31, one per cycle → each value's effect appears at the following edge:
  - OUTPUT=32'h1<<INPUT and INDEX=INPUT.
  - WRAP never asserts.
- RST=1 for 2 cycles with MODE=01 → OUTPUT=32'h00000001, INDEX=0, WRAP=0.
  - After release, first INDEX=1 appears 4 edges later, then +1 every 4 cycles.
- MODE=01 from INDEX=30 → INDEX goes 31 then 0, and WRAP=1 for exactly the one cycle where INDEX=0.
  - MODE=10 from INDEX=1 → INDEX goes 0 then 31, and WRAP=1 with INDEX=31.
- MODE=01 with LOAD=1, INPUT=17 asserted on the prescaler terminal-count edge → INDEX=17, not 18, and OUTPUT=32'h00020000.
  - Next step to 18 comes 4 edges later.
- MODE=01 at INDEX=5: EN low for 10 cycles → no change. Then MODE=11 → OUTPUT=0 and INDEX stays 5.
  - Then MODE=01 → OUTPUT=32'h00000020 at the next edge, and INDEX=6 4 edges later.
- Parameter check, IN_W=3, PRESCALE=1, MODE=10 from 0 → INDEX steps 7,6,…,0,7 every cycle, and OUTPUT is 8 bits one-hot.
